mc_cpu: RTL
===========

// Module: mc_cpu
// PURPOSE
//  Multi-cycle MIPS-subset CPU; successor to the single-cycle core. One unified memory port with req/ready handshake (wait states).
//  FSM sequences FETCH/DECODE/EXEC/MEM/WB and traps illegal/misaligned ops to HALT. Adds retired-instruction counter; regfile/ALU internal.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset (word aligned)
//  CNT_W     32             width of instret counter
// PORTS
//  Clk        in   1      clock, rising edge
//  Clrn       in   1      reset, asynchronous, active-low
//  mem_req    out  1      memory request valid
//  mem_we     out  1      1=store, 0=load/fetch
//  mem_addr   out  32     byte address, always word aligned when mem_req=1
//  mem_wdata  out  32     store data
//  mem_rdata  in   32     read data, valid in cycle mem_ready=1
//  mem_ready  in   1      transfer completes in cycle where mem_req&mem_ready
//  halt       out  1      core stopped (trap); sticky until Clrn
//  pc_o       out  32     architectural PC of current instruction
//  instret    out  CNT_W  retired instruction count
// BEHAVIOUR
//  Reset (Clrn=0, async): state=FETCH, pc=RESET_PC, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halt=0, instret=0,
//   all 32 regs=0. Clrn low mid-transfer aborts it immediately; mem_req=0 combinationally w.r.t. reset.
//  ISA: R: add sub and or xor slt sll srl jr; I: addi andi ori xori lui lw sw beq bne; J: j jal. 32-bit wrapping arithmetic, no overflow trap.
//   addi/slt signed; andi/ori/xori zero-extend imm; lui = imm<<16; sll/srl use shamt[10:6]. $0 reads 0, writes ignored.
//  Handshake: mem_req/mem_we/mem_addr/mem_wdata registered, held stable while mem_req=1 && mem_ready=0.
//   mem_ready ignored when mem_req=0. After a completing cycle mem_req drops for >=1 cycle (next state not a request).
//  FSM (one cycle per state unless waiting):
//   FETCH : req addr=pc, we=0; on ready IR<=rdata, npc<=pc+4 -> DECODE.
//   DECODE: A<=R[rs], B<=R[rt]; illegal opcode/funct -> HALT; else -> EXEC.
//   EXEC  : ALU. beq/bne: pc<=taken ? npc+(sext(imm)<<2) : npc -> FETCH.
//           j: pc<={npc[31:28],target,2'b00}; jal: same + R31<=npc; jr: pc<=A -> FETCH.
//           lw/sw: ea=A+sext(imm); ea[1:0]!=0 -> HALT; else -> MEM. others -> WB.
//   MEM   : req addr=ea; sw: we=1 wdata=B, on ready pc<=npc -> FETCH; lw: on ready MDR<=rdata -> WB.
//   WB    : write rd (R) / rt (I, lw); pc<=npc -> FETCH.
//   HALT  : absorbing; mem_req=0, halt=1, pc/instret frozen.
//  jr to misaligned target: detected at FETCH entry (pc[1:0]!=0) -> HALT without issuing req.
//  instret += 1 on each instruction's final state completion (EXEC for branch/jump, MEM for sw, WB otherwise); wraps at 2^CNT_W.
//   Trapped instructions do not retire.
//  Zero-wait latency (ready same cycle as req): ALU/I-type 4 cycles, lw 5, sw 4, branch/j/jal/jr 3. Each wait cycle adds 1.
//  pc_o = pc; updates only at instruction completion.
// TESTING
//  1 Reset: Clrn=0 with RESET_PC=0x100 -> mem_req=0,halt=0,pc_o=0x100,instret=0; release -> next edge mem_req=1,mem_addr=0x100,mem_we=0.
//  2 ALU: addi $1,$0,5; addi $2,$1,-3; add $3,$1,$2; sw $3,0x40($0) -> write at 0x40 data 7, mem_we=1; instret=4 after 16 cycles, zero-wait.
//  3 Wait states: hold mem_ready=0 3 cycles during FETCH and lw MEM -> req/addr/we stable, no state advance, lw total 11 cycles, loaded value correct.
//  4 Control: beq $0,$0,+2 -> pc=npc+8; bne $0,$0 -> pc=npc; jal 0x40 at pc 0x10 -> R31=0x14, pc=0x100; jr $31 -> pc=0x14.
//  5 Traps: opcode 6'h3F -> halt=1 after DECODE, mem_req stays 0, instret unchanged; lw from 0x42 -> halt; jr to 0x103 -> halt, no fetch.
//  6 Reset mid-op: Clrn=0 while sw in MEM with ready=0 -> mem_req=0 same cycle; restart fetches RESET_PC, regs cleared, instret=0.

Source files
------------

// File: rtl/mc_cpu.sv
// Multi-cycle MIPS-subset core with a single req/ready memory port.
// Illegal opcodes, misaligned data accesses and misaligned fetch targets trap to a sticky HALT.
module mc_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Clrn,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic             halt,
  output logic [31:0]      pc_o,
  output logic [CNT_W-1:0] instret
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [5:0] OP_R    = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR   = 6'h08, FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22, FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  state_t            r_state;
  logic [31:0]       r_pc, r_npc, r_ir, r_a, r_b, r_alu, r_mdr;
  logic [31:0]       r_addr, r_wdata;
  logic              r_req, r_we, r_halt;
  logic [CNT_W-1:0]  r_instret;
  logic [31:0]       r_regs [0:31];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [31:0] w_simm, w_zimm, w_ea, w_ctl_pc, w_alu, w_wb_data;
  logic [4:0]  w_wb_dest;
  logic        w_legal, w_is_jr, w_is_ctl, w_is_mem, w_taken;

  assign w_op      = r_ir[31:26];
  assign w_rs      = r_ir[25:21];
  assign w_rt      = r_ir[20:16];
  assign w_rd      = r_ir[15:11];
  assign w_shamt   = r_ir[10:6];
  assign w_funct   = r_ir[5:0];
  assign w_simm    = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_zimm    = {16'h0000, r_ir[15:0]};
  assign w_ea      = r_a + w_simm;
  assign w_is_jr   = (w_op == OP_R) && (w_funct == FN_JR);
  assign w_is_ctl  = (w_op == OP_BEQ) || (w_op == OP_BNE) || (w_op == OP_J) ||
                     (w_op == OP_JAL) || w_is_jr;
  assign w_is_mem  = (w_op == OP_LW) || (w_op == OP_SW);
  assign w_taken   = (w_op == OP_BEQ) ? (r_a == r_b) : (r_a != r_b);
  assign w_wb_dest = (w_op == OP_R) ? w_rd : w_rt;
  assign w_wb_data = (w_op == OP_LW) ? r_mdr : r_alu;

  always_comb begin
    w_legal = 1'b0;
    case (w_op)
      OP_R: begin
        case (w_funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT, FN_SLL, FN_SRL, FN_JR: w_legal = 1'b1;
          default: w_legal = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
      OP_LUI, OP_LW, OP_SW: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_alu = 32'h0;
    case (w_op)
      OP_R: begin
        case (w_funct)
          FN_ADD:  w_alu = r_a + r_b;
          FN_SUB:  w_alu = r_a - r_b;
          FN_AND:  w_alu = r_a & r_b;
          FN_OR:   w_alu = r_a | r_b;
          FN_XOR:  w_alu = r_a ^ r_b;
          FN_SLT:  w_alu = {31'b0, ($signed(r_a) < $signed(r_b))};
          FN_SLL:  w_alu = r_b << w_shamt;
          FN_SRL:  w_alu = r_b >> w_shamt;
          default: w_alu = 32'h0;
        endcase
      end
      OP_ADDI: w_alu = r_a + w_simm;
      OP_ANDI: w_alu = r_a & w_zimm;
      OP_ORI:  w_alu = r_a | w_zimm;
      OP_XORI: w_alu = r_a ^ w_zimm;
      OP_LUI:  w_alu = {r_ir[15:0], 16'h0000};
      default: w_alu = 32'h0;
    endcase
  end

  always_comb begin
    w_ctl_pc = r_npc;
    if (w_is_jr)
      w_ctl_pc = r_a;
    else if ((w_op == OP_J) || (w_op == OP_JAL))
      w_ctl_pc = {r_npc[31:28], r_ir[25:0], 2'b00};
    else if (((w_op == OP_BEQ) || (w_op == OP_BNE)) && w_taken)
      w_ctl_pc = r_npc + (w_simm << 2);
  end

  // A FETCH entered with r_req=0 is an issue cycle; an unaligned pc traps there before any request.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_npc     <= 32'h0;
      r_ir      <= 32'h0;
      r_a       <= 32'h0;
      r_b       <= 32'h0;
      r_alu     <= 32'h0;
      r_mdr     <= 32'h0;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_halt    <= 1'b0;
      r_instret <= '0;
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_req) begin
            if (r_pc[1:0] != 2'b00) begin
              r_state <= S_HALT;
              r_halt  <= 1'b1;
            end else begin
              r_req  <= 1'b1;
              r_we   <= 1'b0;
              r_addr <= r_pc;
            end
          end else if (mem_ready) begin
            r_ir    <= mem_rdata;
            r_npc   <= r_pc + 32'd4;
            r_req   <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a <= r_regs[w_rs];
          r_b <= r_regs[w_rt];
          if (!w_legal) begin
            r_state <= S_HALT;
            r_halt  <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_ctl) begin
            r_pc      <= w_ctl_pc;
            r_instret <= r_instret + CNT_W'(1);
            r_state   <= S_FETCH;
            if (w_op == OP_JAL) r_regs[31] <= r_npc;
            if (w_ctl_pc[1:0] == 2'b00) begin
              r_req  <= 1'b1;
              r_we   <= 1'b0;
              r_addr <= w_ctl_pc;
            end
          end else if (w_is_mem) begin
            if (w_ea[1:0] != 2'b00) begin
              r_state <= S_HALT;
              r_halt  <= 1'b1;
            end else begin
              r_state <= S_MEM;
              r_req   <= 1'b1;
              r_addr  <= w_ea;
              r_we    <= (w_op == OP_SW);
              if (w_op == OP_SW) r_wdata <= r_b;
            end
          end else begin
            r_alu   <= w_alu;
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            if (w_op == OP_SW) begin
              r_pc      <= r_npc;
              r_instret <= r_instret + CNT_W'(1);
              r_state   <= S_FETCH;
            end else begin
              r_mdr   <= mem_rdata;
              r_state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (w_wb_dest != 5'd0) r_regs[w_wb_dest] <= w_wb_data;
          r_pc      <= r_npc;
          r_instret <= r_instret + CNT_W'(1);
          r_state   <= S_FETCH;
          r_req     <= 1'b1;
          r_we      <= 1'b0;
          r_addr    <= r_npc;
        end
        S_HALT: begin
          r_req <= 1'b0;
          r_we  <= 1'b0;
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign halt      = r_halt;
  assign pc_o      = r_pc;
  assign instret   = r_instret;
endmodule
